// File: rtl/reg_file_mp_pkg.sv
// Shared constants and helpers for the multi-ported register file.
// Optional macro REGFILE_BYPASS_EN enables write-to-read bypass in reg_file_mp.
package regfile_pkg;

  localparam int XLEN_DEF = 32;
  localparam int ZERO_REG = 0;

  function automatic int addr_width(input int nregs);
    return (nregs <= 1) ? 1 : $clog2(nregs);
  endfunction

endpackage

// File: rtl/reg_file_mp_if.sv
// Read/write/issue bus of the register file; master drives requests, slave returns data.
// Optional macro REGFILE_BYPASS_EN changes slave read timing only, not this bundle.
interface reg_file_mp_if #(
  parameter int XLEN  = regfile_pkg::XLEN_DEF,
  parameter int NREGS = 32,
  parameter int NRD   = 2,
  parameter int NWR   = 2
);
  localparam int AW = regfile_pkg::addr_width(NREGS);

  logic [NRD*AW-1:0]   raddr;
  logic [NRD*XLEN-1:0] rdata;
  logic [NRD-1:0]      rbusy;
  logic [NWR-1:0]      we;
  logic [NWR*AW-1:0]   waddr;
  logic [NWR*XLEN-1:0] wdata;
  logic                issue_valid;
  logic [AW-1:0]       issue_rd;

  modport master (
    output raddr, we, waddr, wdata, issue_valid, issue_rd,
    input  rdata, rbusy
  );

  modport slave (
    input  raddr, we, waddr, wdata, issue_valid, issue_rd,
    output rdata, rbusy
  );

endinterface

// File: rtl/reg_file_mp_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, issue beats write-clear.
// Optional macro REGFILE_BYPASS_EN does not affect this module.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS = 32,
  parameter int NWR   = 2,
  parameter int AW    = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue_valid_i,
  input  logic [AW-1:0]     issue_rd_i,
  input  logic [NWR-1:0]    we_i,
  input  logic [NWR*AW-1:0] waddr_i,
  output logic [NREGS-1:0]  busy_o
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;
  logic [NREGS-1:0] set_s;
  logic [NREGS-1:0] clr_s;

  // Decode per-register set (issue) and clear (any write) requests.
  always_comb begin
    set_s = '0;
    clr_s = '0;
    for (int r = 0; r < NREGS; r++) begin
      set_s[r] = issue_valid_i && (issue_rd_i == AW'(r));
      for (int j = 0; j < NWR; j++) begin
        clr_s[r] = clr_s[r] | (we_i[j] && (waddr_i[j*AW +: AW] == AW'(r)));
      end
    end
    busy_d = ((busy_q & ~clr_s) | set_s) & ~(NREGS'(1) << ZERO_REG);
  end

  // Busy vector state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_o = busy_q;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-ported register file with x0 hardwired to zero and a pending-write scoreboard.
// Optional macro REGFILE_BYPASS_EN: same-cycle write data and busy-clear forward to reads.
module reg_file_mp
  import regfile_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = 32,
  parameter int NRD   = 2,
  parameter int NWR   = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  reg_file_mp_if.slave bus
);

  localparam int AW = addr_width(NREGS);

  logic [XLEN-1:0]     regs_q [NREGS];
  logic [XLEN-1:0]     regs_d [NREGS];
  logic [NREGS-1:0]    busy_s;
  logic [NRD*XLEN-1:0] rdata_s;
  logic [NRD-1:0]      rbusy_s;

  regfile_scoreboard #(
    .NREGS (NREGS),
    .NWR   (NWR),
    .AW    (AW)
  ) u_scoreboard (
    .clk           (clk),
    .rst_n         (rst_n),
    .issue_valid_i (bus.issue_valid),
    .issue_rd_i    (bus.issue_rd),
    .we_i          (bus.we),
    .waddr_i       (bus.waddr),
    .busy_o        (busy_s)
  );

  // Write merge: ascending port order so the highest-index port lands last; x0 is skipped.
  always_comb begin
    regs_d = regs_q;
    for (int j = 0; j < NWR; j++) begin
      for (int r = 1; r < NREGS; r++) begin
        regs_d[r] = (bus.we[j] && (bus.waddr[j*AW +: AW] == AW'(r)))
                    ? bus.wdata[j*XLEN +: XLEN] : regs_d[r];
      end
    end
  end

  // Register storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++) begin
        regs_q[r] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Combinational read ports.
  always_comb begin
    rdata_s = '0;
    rbusy_s = '0;
    for (int i = 0; i < NRD; i++) begin
      logic [AW-1:0]   ra;
      logic [XLEN-1:0] rd;
      logic            bsy;
`ifdef REGFILE_BYPASS_EN
      logic            byp_hit;
      logic [XLEN-1:0] byp_data;
      logic            iss_hit;
`endif
      ra  = bus.raddr[i*AW +: AW];
      rd  = regs_q[ra];
      bsy = busy_s[ra];
`ifdef REGFILE_BYPASS_EN
      byp_hit  = 1'b0;
      byp_data = '0;
      for (int j = 0; j < NWR; j++) begin
        byp_hit  = (bus.we[j] && (bus.waddr[j*AW +: AW] == ra)) ? 1'b1 : byp_hit;
        byp_data = (bus.we[j] && (bus.waddr[j*AW +: AW] == ra))
                   ? bus.wdata[j*XLEN +: XLEN] : byp_data;
      end
      iss_hit = bus.issue_valid && (bus.issue_rd == ra);
      rd  = byp_hit ? byp_data : rd;
      bsy = bsy & ~(byp_hit & ~iss_hit);
`endif
      rdata_s[i*XLEN +: XLEN] = (ra == AW'(ZERO_REG)) ? '0 : rd;
      rbusy_s[i]              = (ra == AW'(ZERO_REG)) ? 1'b0 : bsy;
    end
  end

  assign bus.rdata = rdata_s;
  assign bus.rbusy = rbusy_s;

endmodule

// File: tb/tb_reg_file_mp.sv
// Self-checking bench for reg_file_mp: architectural model plus directed literal checks.
// Honours REGFILE_BYPASS_EN when the same macro is defined for the bench.
module tb_reg_file_mp;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int NWR   = 2;
  localparam int AW    = 5;

  logic clk;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;

  reg_file_mp_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) bus ();

  reg_file_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Architectural state as a programmer sees it.
  logic [XLEN-1:0] mdl_reg  [NREGS];
  logic            mdl_busy [NREGS];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++) begin
        mdl_reg[r]  <= 32'h0;
        mdl_busy[r] <= 1'b0;
      end
    end else begin
      for (int j = 0; j < NWR; j++) begin
        if (bus.we[j] && bus.waddr[j*AW +: AW] != 5'd0)
          mdl_reg[bus.waddr[j*AW +: AW]] <= bus.wdata[j*XLEN +: XLEN];
        if (bus.we[j])
          mdl_busy[bus.waddr[j*AW +: AW]] <= 1'b0;
      end
      if (bus.issue_valid && bus.issue_rd != 5'd0)
        mdl_busy[bus.issue_rd] <= 1'b1;
    end
  end

  function automatic logic [XLEN-1:0] exp_rdata(input int p);
    logic [AW-1:0]   a;
    logic [XLEN-1:0] v;
    a = bus.raddr[p*AW +: AW];
    v = mdl_reg[a];
`ifdef REGFILE_BYPASS_EN
    for (int j = 0; j < NWR; j++)
      if (bus.we[j] && bus.waddr[j*AW +: AW] == a) v = bus.wdata[j*XLEN +: XLEN];
`endif
    if (!rst_n || a == 5'd0) v = 32'h0;
    return v;
  endfunction

  function automatic logic exp_rbusy(input int p);
    logic [AW-1:0] a;
    logic          b;
    a = bus.raddr[p*AW +: AW];
    b = mdl_busy[a];
`ifdef REGFILE_BYPASS_EN
    for (int j = 0; j < NWR; j++)
      if (bus.we[j] && bus.waddr[j*AW +: AW] == a && !(bus.issue_valid && bus.issue_rd == a)) b = 1'b0;
`endif
    if (!rst_n || a == 5'd0) b = 1'b0;
    return b;
  endfunction

  task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Continuous comparison against the model, away from the active edge.
  always @(negedge clk) begin
    for (int p = 0; p < NRD; p++) begin
      chk($sformatf("model_rdata%0d", p), bus.rdata[p*XLEN +: XLEN], exp_rdata(p));
      chk($sformatf("model_rbusy%0d", p), {31'd0, bus.rbusy[p]}, {31'd0, exp_rbusy(p)});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.we          = 2'b00;
    bus.waddr       = 10'd0;
    bus.wdata       = 64'd0;
    bus.issue_valid = 1'b0;
    bus.issue_rd    = 5'd0;
  endtask

  task automatic rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    bus.raddr = {a1, a0};
  endtask

  logic [XLEN-1:0] same_cycle_exp;

  initial begin
    rst_n = 1'b0;
    idle();
    rd(5'd0, 5'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // All addresses read zero and idle after reset.
    for (int a = 0; a < NREGS; a++) begin
      rd(AW'(a), AW'(NREGS - 1 - a));
      @(negedge clk);
      chk("reset_rdata0", bus.rdata[31:0], 32'h0);
      chk("reset_rbusy", {30'd0, bus.rbusy}, 32'h0);
      tick();
    end

    // Single write then read, including same-cycle visibility.
`ifdef REGFILE_BYPASS_EN
    same_cycle_exp = 32'hAAAABBBB;
`else
    same_cycle_exp = 32'h0;
`endif
    bus.we = 2'b01; bus.waddr = {5'd0, 5'd5}; bus.wdata = {32'h0, 32'hAAAABBBB};
    rd(5'd5, 5'd0);
    @(negedge clk);
    chk("x5_same_cycle", bus.rdata[31:0], same_cycle_exp);
    tick();
    idle();
    @(negedge clk);
    chk("x5_next_cycle", bus.rdata[31:0], 32'hAAAABBBB);
    tick();

    // Dual write to the same address: port 1 wins.
    bus.we = 2'b11; bus.waddr = {5'd10, 5'd10}; bus.wdata = {32'h22222222, 32'h11111111};
    tick();
    idle();
    rd(5'd5, 5'd10);
    @(negedge clk);
    chk("x10_port1_wins", bus.rdata[63:32], 32'h22222222);
    tick();

    // Writes and issues to x0 are ignored.
    bus.we = 2'b10; bus.waddr = {5'd0, 5'd0}; bus.wdata = {32'hFFFFFFFF, 32'h0};
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd0;
    tick();
    idle();
    rd(5'd0, 5'd0);
    @(negedge clk);
    chk("x0_data", bus.rdata[31:0], 32'h0);
    chk("x0_busy", {31'd0, bus.rbusy[0]}, 32'h0);
    tick();

    // Scoreboard: issue, re-issue with write, then plain write clears.
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd7;
    tick();
    idle();
    rd(5'd7, 5'd7);
    @(negedge clk);
    chk("x7_busy_after_issue", {31'd0, bus.rbusy[0]}, 32'h1);
    tick();
    bus.we = 2'b01; bus.waddr = {5'd0, 5'd7}; bus.wdata = {32'h0, 32'hDEADBEEF};
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd7;
    tick();
    idle();
    @(negedge clk);
    chk("x7_busy_issue_wins", {31'd0, bus.rbusy[1]}, 32'h1);
    tick();
    bus.we = 2'b10; bus.waddr = {5'd7, 5'd0}; bus.wdata = {32'hDEADBEEF, 32'h0};
    tick();
    idle();
    @(negedge clk);
    chk("x7_busy_cleared", {31'd0, bus.rbusy[0]}, 32'h0);
    chk("x7_data", bus.rdata[31:0], 32'hDEADBEEF);
    tick();

    // Mixed traffic checked by the model only.
    for (int k = 0; k < 60; k++) begin
      bus.we          = NWR'($urandom_range(0, 3));
      bus.waddr       = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))};
      bus.wdata       = {32'($urandom), 32'($urandom)};
      bus.issue_valid = 1'($urandom_range(0, 1));
      bus.issue_rd    = AW'($urandom_range(0, 7));
      rd(AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
      tick();
    end
    idle();

    // Reset pulse between edges wipes data and busy bits at once.
    bus.we = 2'b01; bus.waddr = {5'd0, 5'd20}; bus.wdata = {32'h0, 32'hCAFECAFE};
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd9;
    tick();
    idle();
    rd(5'd20, 5'd9);
    @(negedge clk);
    chk("x20_before_reset", bus.rdata[31:0], 32'hCAFECAFE);
    chk("x9_busy_before_reset", {31'd0, bus.rbusy[1]}, 32'h1);
    tick();
    rst_n = 1'b0;
    #1;
    chk("x20_in_reset", bus.rdata[31:0], 32'h0);
    chk("busy_in_reset", {30'd0, bus.rbusy}, 32'h0);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("x20_after_reset", bus.rdata[31:0], 32'h0);
    chk("x9_busy_after_reset", {31'd0, bus.rbusy[1]}, 32'h0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/reg_file_mp.md
REG_FILE_MP -- requirements
Module: reg_file_mp

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width in bits.
REQ-002 SHALL have parameter NREGS, default 32, register count (power of two, >=2); AW = log2(NREGS).
REQ-003 SHALL have parameter NRD, default 2, number of read ports.
REQ-004 SHALL have parameter NWR, default 2, number of write ports.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 raddr  input  NRD*AW  read addresses; port i at bits [i*AW +: AW].
REQ-008 rdata  output  NRD*XLEN  read data; port i at bits [i*XLEN +: XLEN].
REQ-009 rbusy  output  NRD  per-read-port scoreboard busy flag for raddr[i].
REQ-010 we  input  NWR  per-port write enable.
REQ-011 waddr  input  NWR*AW  write addresses, packed as raddr.
REQ-012 wdata  input  NWR*XLEN  write data, packed as rdata.
REQ-013 issue_valid  input  1  marks register issue_rd as pending.
REQ-014 issue_rd  input  AW  destination register being issued.

Function
REQ-015 Register 0 SHALL read as 0 always; writes to address 0 SHALL be discarded; rbusy for address 0 SHALL always be 0.
REQ-016 Reads SHALL be combinational: rdata[i] = reg[raddr[i]] with zero added cycles of latency.
REQ-017 Write on port j SHALL update reg[waddr[j]] at the rising edge where we[j]=1; no update when we[j]=0.
REQ-018 Two or more enabled write ports to the same nonzero address in one cycle: the highest-index port SHALL win.
REQ-019 Scoreboard: busy[r] SHALL be set at the edge where issue_valid=1 and issue_rd=r (r!=0).
REQ-020 busy[r] SHALL be cleared at the edge where any we[j]=1 with waddr[j]=r.
REQ-021 Simultaneous issue and write to the same r: issue SHALL win, busy[r]=1 after the edge (new producer).
REQ-022 Issue of an already-busy register SHALL leave it busy; write to a non-busy register SHALL leave it clear.
REQ-023 rbusy[i] SHALL reflect busy[raddr[i]] registered state (no same-cycle forwarding of issue or clear).

Reset
REQ-024 While rst_n=0, all registers SHALL be 0 and all busy bits 0, immediately and independent of clk.
REQ-025 Reset asserted mid-write SHALL abort the write; after release reg contents are 0.
REQ-026 Consequently rdata and rbusy SHALL be 0 for every port during reset.

Configuration
REQ-027 Macro REGFILE_BYPASS_EN defined: a read of address a in the cycle an enabled write (winning port per REQ-018) targets a!=0 SHALL return that wdata combinationally, and rbusy SHALL read 0 for that port unless issue_valid also targets a.
REQ-028 REGFILE_BYPASS_EN undefined: rdata returns the pre-edge value; new value visible from the next cycle; rbusy per REQ-023 only.

Structure
REQ-029 Package regfile_pkg SHALL hold XLEN default, the address-width function (clog2), and constant ZERO_REG = 0.
REQ-030 Scoreboard SHALL be a sub-module regfile_scoreboard (busy vector, set/clear priority, reset); storage and bypass muxing stay in reg_file_mp.

Verification
REQ-031 Reset then read all 32 addresses on both ports -> rdata=0, rbusy=0 everywhere.
REQ-032 we[0]=1, waddr=5, wdata=32'hAAAABBBB; next cycle raddr[0]=5 -> 32'hAAAABBBB; same-cycle read -> AAAABBBB with bypass, 0 without.
REQ-033 we=2'b11, both waddr=10, wdata0=32'h11111111, wdata1=32'h22222222 -> x10 reads 32'h22222222.
REQ-034 we[1]=1, waddr=0, wdata=32'hFFFFFFFF; issue_rd=0 -> x0 reads 0, rbusy 0.
REQ-035 issue_valid, issue_rd=7 -> rbusy for x7 =1 next cycle; write x7=32'hDEADBEEF with simultaneous issue_rd=7 -> still busy; later write without issue -> busy 0, data DEADBEEF.
REQ-036 Write x20=32'hCAFECAFE, then pulse rst_n low between edges -> x20 reads 0 immediately, all busy 0.
